// File: rtl/mempool_pkg.sv
// Shared constants and helpers for the tile remote-port allocator.
package mempool_pkg;

  localparam int unsigned NumCoresPerTile              = 4;
  localparam int unsigned NumRdRemoteReqPortsPerTile   = 0;
  localparam int unsigned NumRdWrRemoteReqPortsPerTile = 4;
  localparam int unsigned NumWrRemoteReqPortsPerTile   = 0;
  localparam int unsigned NumRemoteReqPortsPerTile     = NumRdRemoteReqPortsPerTile +
                                                         NumRdWrRemoteReqPortsPerTile +
                                                         NumWrRemoteReqPortsPerTile;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Port 0 is the local group, ports 1..NumRemoteReqPortsPerTile are remote.
  localparam int unsigned RemotePortsIdxWidth = idx_width(NumRemoteReqPortsPerTile + 1);
  typedef logic [RemotePortsIdxWidth-1:0] remote_ports_index_t;

endpackage

// File: rtl/mempool_port_rank.sv
// Rotated prefix popcount: for each core, how many masked cores precede it
// in the round-robin order that starts at prio; also the total masked count.
module mempool_port_rank import mempool_pkg::*; #(
  parameter  int unsigned NumCores = 4,
  localparam int unsigned PrioW    = idx_width(NumCores),
  localparam int unsigned RankW    = idx_width(NumCores + 1)
) (
  input  logic [NumCores-1:0]            mask,
  input  logic [PrioW-1:0]               prio,
  output logic [NumCores-1:0][RankW-1:0] rank,
  output logic [RankW-1:0]               total
);

  // Position of a core in the rotated order (prio is position 0).
  function automatic int unsigned rot_pos(input int unsigned idx, input logic [PrioW-1:0] p);
    return (idx + NumCores - 32'(p)) % NumCores;
  endfunction

  // Count earlier masked cores for every core, and the overall population.
  always_comb begin
    rank  = '0;
    total = '0;
    for (int unsigned c = 0; c < NumCores; c++) begin
      for (int unsigned j = 0; j < NumCores; j++) begin
        if (mask[j] && (rot_pos(j, prio) < rot_pos(c, prio))) begin
          rank[c] = rank[c] + RankW'(1);
        end
      end
      if (mask[c]) begin
        total = total + RankW'(1);
      end
    end
  end

endmodule

// File: rtl/mempool_remote_port_allocator.sv
// Per-tile allocator choosing a request port for each core: port 0 for the
// local group, otherwise a remote port picked statically or by rotating
// pointers, with sticky per-core locks holding the choice until handshake.
module mempool_remote_port_allocator import mempool_pkg::*; #(
  parameter  int unsigned NumCores       = NumCoresPerTile,
  parameter  int unsigned NumRdPorts     = NumRdRemoteReqPortsPerTile,
  parameter  int unsigned NumRdWrPorts   = NumRdWrRemoteReqPortsPerTile,
  parameter  int unsigned NumWrPorts     = NumWrRemoteReqPortsPerTile,
  parameter  int unsigned GroupIdWidth   = 2,
  parameter  bit          DynamicAlloc   = 1'b1,
  localparam int unsigned NumRemotePorts = NumRdPorts + NumRdWrPorts + NumWrPorts,
  localparam int unsigned SelW           = idx_width(NumRemotePorts + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [GroupIdWidth-1:0]          group_id_i,
  input  logic [NumCores*GroupIdWidth-1:0] tgt_group_i,
  input  logic [NumCores-1:0]              valid_i,
  input  logic [NumCores-1:0]              wr_i,
  input  logic [NumCores-1:0]              ready_i,
  output logic [NumCores-1:0]              valid_o,
  output logic [NumCores-1:0]              ready_o,
  output logic [NumCores*SelW-1:0]         tgt_sel_o,
  output logic [NumCores-1:0]              locked_o
);

  // With no dedicated read or write ports, reads and writes share one pointer.
  localparam bit          Shared  = (NumRdPorts == 0) && (NumWrPorts == 0);
  localparam int unsigned RdBase  = 1;
  localparam int unsigned RdSize  = NumRdPorts + NumRdWrPorts;
  localparam int unsigned WrBase  = 1 + NumRdPorts;
  localparam int unsigned WrSize  = NumRdWrPorts + NumWrPorts;
  localparam int unsigned RdSizeG = (RdSize > 0) ? RdSize : 1;
  localparam int unsigned WrSizeG = (WrSize > 0) ? WrSize : 1;
  localparam int unsigned RdPtrW  = idx_width(RdSizeG);
  localparam int unsigned WrPtrW  = idx_width(WrSizeG);
  localparam int unsigned PrioW   = idx_width(NumCores);
  localparam int unsigned RankW   = idx_width(NumCores + 1);

  logic [NumCores-1:0]            is_remote;
  logic [NumCores-1:0]            is_new;
  logic [NumCores-1:0]            use_wr;
  logic [NumCores-1:0]            rd_mask;
  logic [NumCores-1:0]            wr_mask;
  logic [NumCores-1:0][RankW-1:0] rd_rank;
  logic [NumCores-1:0][RankW-1:0] wr_rank;
  logic [RankW-1:0]               rd_total;
  logic [RankW-1:0]               wr_total;
  logic [NumCores-1:0][SelW-1:0]  sel;

  logic [NumCores-1:0]            lock_q;
  logic [NumCores-1:0][SelW-1:0]  lock_port_q;
  logic [RdPtrW-1:0]              rd_ptr_q;
  logic [WrPtrW-1:0]              wr_ptr_q;
  logic [PrioW-1:0]               prio_q;

  // Classify each request: remote or local, read or write class, newly allocated or not.
  always_comb begin
    is_remote = '0;
    is_new    = '0;
    use_wr    = '0;
    rd_mask   = '0;
    wr_mask   = '0;
    for (int unsigned c = 0; c < NumCores; c++) begin
      is_remote[c] = tgt_group_i[c*GroupIdWidth +: GroupIdWidth] != group_id_i;
      is_new[c]    = DynamicAlloc && valid_i[c] && is_remote[c] && !lock_q[c];
      use_wr[c]    = !Shared && wr_i[c];
      rd_mask[c]   = is_new[c] && !use_wr[c];
      wr_mask[c]   = is_new[c] && use_wr[c];
    end
  end

  mempool_port_rank #(.NumCores(NumCores)) i_rd_rank (
    .mask  (rd_mask),
    .prio  (prio_q),
    .rank  (rd_rank),
    .total (rd_total)
  );

  mempool_port_rank #(.NumCores(NumCores)) i_wr_rank (
    .mask  (wr_mask),
    .prio  (prio_q),
    .rank  (wr_rank),
    .total (wr_total)
  );

  // Pick the port per core: held lock port, local port 0, or a class-relative remote port.
  always_comb begin
    sel = '0;
    for (int unsigned c = 0; c < NumCores; c++) begin
      if (lock_q[c]) begin
        sel[c] = lock_port_q[c];
      end else if (is_remote[c]) begin
        if (!DynamicAlloc) begin
          sel[c] = use_wr[c] ? SelW'(WrBase + c % WrSizeG) : SelW'(RdBase + c % RdSizeG);
        end else if (use_wr[c]) begin
          sel[c] = SelW'(WrBase + (32'(wr_ptr_q) + 32'(wr_rank[c])) % WrSizeG);
        end else begin
          sel[c] = SelW'(RdBase + (32'(rd_ptr_q) + 32'(rd_rank[c])) % RdSizeG);
        end
      end
    end
  end

  // Track sticky locks, advance class pointers by the number of new requests, rotate priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q      <= '0;
      lock_port_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      prio_q      <= '0;
    end else begin
      for (int unsigned c = 0; c < NumCores; c++) begin
        if (lock_q[c]) begin
          if (!valid_i[c] || ready_i[c]) begin
            lock_q[c] <= 1'b0;
          end
        end else if (is_new[c] && !ready_i[c]) begin
          lock_q[c]      <= 1'b1;
          lock_port_q[c] <= sel[c];
        end
      end
      if (DynamicAlloc) begin
        rd_ptr_q <= RdPtrW'((32'(rd_ptr_q) + 32'(rd_total)) % RdSizeG);
        wr_ptr_q <= WrPtrW'((32'(wr_ptr_q) + 32'(wr_total)) % WrSizeG);
      end
      prio_q <= (32'(prio_q) == NumCores - 1) ? '0 : prio_q + PrioW'(1);
    end
  end

  assign valid_o   = valid_i;
  assign ready_o   = ready_i;
  assign tgt_sel_o = sel;
  assign locked_o  = lock_q;

endmodule

// File: tb/tb_mempool_remote_port_allocator.sv
// Bench: three allocator configurations (dynamic shared, static shared, dynamic
// split read/write) driven by the same stimulus and checked against a walk-order model.
module tb_mempool_remote_port_allocator;

  localparam int NC = 4;
  localparam int SW = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grp = 2'd0;
  logic [7:0] tgt = 8'h55;
  logic [3:0] valid = 4'hF;
  logic [3:0] wr = 4'h0;
  logic [3:0] ready = 4'h0;

  logic [3:0]    vo [3];
  logic [3:0]    ro [3];
  logic [3:0]    lk [3];
  logic [NC*SW-1:0] ts [3];

  int num_checks = 0;
  int num_errors = 0;
  bit check_en = 1'b0;

  // Configuration table: index 0 dynamic shared, 1 static shared, 2 dynamic split.
  int cfg_dyn [3] = '{1, 0, 1};
  int cfg_rd  [3] = '{0, 0, 2};
  int cfg_rw  [3] = '{4, 4, 0};
  int cfg_wr  [3] = '{0, 0, 2};

  // Model state per configuration.
  bit m_lock [3][4];
  int m_port [3][4];
  int m_ptr  [3][2];
  int m_prio [3];

  // Model scratch results of the current cycle.
  int exp_sel  [4];
  bit exp_new  [4];
  int exp_cnt  [2];
  int exp_size [2];

  always #5 clk = ~clk;

  mempool_remote_port_allocator #(.NumRdPorts(0), .NumRdWrPorts(4), .NumWrPorts(0),
    .GroupIdWidth(2), .DynamicAlloc(1'b1)) dut_dyn (
    .clk_i(clk), .rst_i(rst), .group_id_i(grp), .tgt_group_i(tgt), .valid_i(valid),
    .wr_i(wr), .ready_i(ready), .valid_o(vo[0]), .ready_o(ro[0]), .tgt_sel_o(ts[0]),
    .locked_o(lk[0]));

  mempool_remote_port_allocator #(.NumRdPorts(0), .NumRdWrPorts(4), .NumWrPorts(0),
    .GroupIdWidth(2), .DynamicAlloc(1'b0)) dut_static (
    .clk_i(clk), .rst_i(rst), .group_id_i(grp), .tgt_group_i(tgt), .valid_i(valid),
    .wr_i(wr), .ready_i(ready), .valid_o(vo[1]), .ready_o(ro[1]), .tgt_sel_o(ts[1]),
    .locked_o(lk[1]));

  mempool_remote_port_allocator #(.NumRdPorts(2), .NumRdWrPorts(0), .NumWrPorts(2),
    .GroupIdWidth(2), .DynamicAlloc(1'b1)) dut_split (
    .clk_i(clk), .rst_i(rst), .group_id_i(grp), .tgt_group_i(tgt), .valid_i(valid),
    .wr_i(wr), .ready_i(ready), .valid_o(vo[2]), .ready_o(ro[2]), .tgt_sel_o(ts[2]),
    .locked_o(lk[2]));

  // Walk cores in priority order, handing out consecutive class slots to new requests.
  function automatic void model_eval(input int k);
    bit shared;
    int base [2];
    int c;
    int cls;
    bit remote;
    shared      = (cfg_rd[k] == 0) && (cfg_wr[k] == 0);
    base[0]     = 1;
    exp_size[0] = cfg_rd[k] + cfg_rw[k];
    base[1]     = shared ? 1 : 1 + cfg_rd[k];
    exp_size[1] = shared ? exp_size[0] : cfg_rw[k] + cfg_wr[k];
    exp_cnt[0]  = 0;
    exp_cnt[1]  = 0;
    for (int step = 0; step < NC; step++) begin
      c          = (m_prio[k] + step) % NC;
      cls        = (!shared && wr[c]) ? 1 : 0;
      remote     = (tgt[c*2 +: 2] != grp);
      exp_new[c] = 1'b0;
      exp_sel[c] = 0;
      if (m_lock[k][c]) begin
        exp_sel[c] = m_port[k][c];
      end else if (remote) begin
        if (cfg_dyn[k] == 0) begin
          exp_sel[c] = base[cls] + c % exp_size[cls];
        end else begin
          exp_sel[c] = base[cls] + (m_ptr[k][cls] + exp_cnt[cls]) % exp_size[cls];
          if (valid[c]) begin
            exp_new[c] = 1'b1;
            exp_cnt[cls]++;
          end
        end
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input logic [1:0] g, input logic [7:0] t,
                               input logic [3:0] v, input logic [3:0] w, input logic [3:0] rd);
    @(posedge clk);
    #1;
    rst   = r;
    grp   = g;
    tgt   = t;
    valid = v;
    wr    = w;
    ready = rd;
    @(negedge clk);
  endtask

  function automatic int sel_of(input int k, input int c);
    logic [NC*SW-1:0] v;
    v = ts[k];
    return int'(v[c*SW +: SW]);
  endfunction

  // Advance the model on every rising edge, mirroring what the allocator should remember.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int c = 0; c < NC; c++) begin
          m_lock[k][c] = 1'b0;
          m_port[k][c] = 0;
        end
        m_ptr[k][0] = 0;
        m_ptr[k][1] = 0;
        m_prio[k]   = 0;
      end else begin
        model_eval(k);
        for (int c = 0; c < NC; c++) begin
          if (m_lock[k][c]) begin
            if (!valid[c] || ready[c]) m_lock[k][c] = 1'b0;
          end else if (exp_new[c] && !ready[c]) begin
            m_lock[k][c] = 1'b1;
            m_port[k][c] = exp_sel[c];
          end
        end
        if (cfg_dyn[k] != 0) begin
          m_ptr[k][0] = (m_ptr[k][0] + exp_cnt[0]) % exp_size[0];
          m_ptr[k][1] = (m_ptr[k][1] + exp_cnt[1]) % exp_size[1];
        end
        m_prio[k] = (m_prio[k] + 1) % NC;
      end
    end
  end

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < 3; k++) begin
        logic [3:0] exp_lk;
        model_eval(k);
        for (int c = 0; c < NC; c++) exp_lk[c] = m_lock[k][c];
        checkOutput($sformatf("locked_o[dut%0d]", k), 32'(lk[k]), 32'(exp_lk));
        checkOutput($sformatf("valid_o[dut%0d]", k), 32'(vo[k]), 32'(valid));
        checkOutput($sformatf("ready_o[dut%0d]", k), 32'(ro[k]), 32'(ready));
        for (int c = 0; c < NC; c++) begin
          if (m_lock[k][c] || valid[c]) begin
            checkOutput($sformatf("tgt_sel[dut%0d][core%0d]", k, c), 32'(sel_of(k, c)), 32'(exp_sel[c]));
          end
        end
      end
    end
  end

  initial begin
    // Reset held three cycles with all cores requesting remote reads.
    applyStimulus(1'b1, 2'd0, 8'h55, 4'hF, 4'h0, 4'h0);
    check_en = 1'b1;
    applyStimulus(1'b1, 2'd0, 8'h55, 4'hF, 4'h0, 4'h0);
    applyStimulus(1'b1, 2'd0, 8'h55, 4'hF, 4'h0, 4'h0);
    checkOutput("reset locked_o", 32'(lk[0]), 32'h0);
    checkOutput("reset dyn tgt_sel", 32'(ts[0]), 32'd2257);
    checkOutput("static tgt_sel", 32'(ts[1]), 32'd2257);

    // Four all-local cycles: port 0 everywhere, priority wraps back to 0.
    applyStimulus(1'b0, 2'd0, 8'h00, 4'hF, 4'h0, 4'h0);
    checkOutput("local tgt_sel", 32'(ts[0]), 32'h0);
    checkOutput("local locked_o", 32'(lk[0]), 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'd0, 8'h00, 4'hF, 4'h0, 4'h0);

    // Cores 0 and 2 allocate with ready low and become locked.
    applyStimulus(1'b0, 2'd0, 8'h55, 4'b0101, 4'h0, 4'h0);
    checkOutput("alloc core0", 32'(sel_of(0, 0)), 32'd1);
    checkOutput("alloc core2", 32'(sel_of(0, 2)), 32'd2);
    applyStimulus(1'b0, 2'd0, 8'h55, 4'b0111, 4'h0, 4'h0);
    checkOutput("locks set", 32'(lk[0]), 32'b0101);
    checkOutput("held core0", 32'(sel_of(0, 0)), 32'd1);
    checkOutput("held core2", 32'(sel_of(0, 2)), 32'd2);
    checkOutput("new core1", 32'(sel_of(0, 1)), 32'd3);

    // Core 0 handshakes, then re-allocates from the advanced pointer.
    applyStimulus(1'b0, 2'd0, 8'h55, 4'b0111, 4'h0, 4'b0001);
    checkOutput("locks before hs", 32'(lk[0]), 32'b0111);
    applyStimulus(1'b0, 2'd0, 8'h55, 4'b0111, 4'h0, 4'h0);
    checkOutput("lock cleared", 32'(lk[0]), 32'b0110);
    checkOutput("realloc core0", 32'(sel_of(0, 0)), 32'd4);

    // Reset in the middle of locked transactions, then split read/write classes.
    applyStimulus(1'b1, 2'd0, 8'h55, 4'b0111, 4'h0, 4'h0);
    applyStimulus(1'b0, 2'd0, 8'h55, 4'b0011, 4'b0001, 4'h0);
    checkOutput("post-reset locked dyn", 32'(lk[0]), 32'h0);
    checkOutput("post-reset locked split", 32'(lk[2]), 32'h0);
    checkOutput("split write core0", 32'(sel_of(2, 0)), 32'd3);
    checkOutput("split read core1", 32'(sel_of(2, 1)), 32'd1);

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(49) == 0, 2'($urandom), 8'($urandom),
                    4'($urandom) | 4'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom));
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", num_errors, num_checks);
    $finish;
  end

endmodule
